// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipelined RV32I control unit.
package pipe_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Next-PC select
    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    // Write-back mux select
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_CSR = 2'b11;

    // ALU A operand select
    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    // Immediate formats; 0 means no immediate used
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_U    = 3'd5;

    // ALU operations; 0 is reserved for a bubble so it never aliases a real op
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SLL  = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_SLTU = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_OR   = 5'd9;
    localparam logic [4:0] ALU_AND  = 5'd10;

    // E-stage control bundle (ALU op and immediate select travel separately
    // because their widths are parameters of the top)
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] funct3;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       illegal;
    } ctrl_t;

    // M- and W-stage bundles only keep what those stages consume
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        CSR_IDLE  = 1'b0,
        CSR_DRAIN = 1'b1
    } csr_state_t;

    // Arithmetic op from funct3; alt selects SUB/SRA
    function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational D-stage decoder: opcode/funct3/funct7[5] to control bundle.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 5,
    parameter int IMMSRC_W  = 3,
    parameter bit CSR_EN    = 1'b1
) (
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    output ctrl_t                ctrl,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [IMMSRC_W-1:0]  imm_src
);

    // Opcode decode; unknown opcodes leave everything zero except illegal
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        alu_ctrl = '0;
        imm_src  = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                alu_ctrl       = ALUCTRL_W'(alu_op(funct3, funct7_5));
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                alu_ctrl       = ALUCTRL_W'(alu_op(funct3, funct7_5 && (funct3 == 3'b101)));
                imm_src        = IMMSRC_W'(IMM_I);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src_b  = 1'b1;
                alu_ctrl        = ALUCTRL_W'(ALU_ADD);
                imm_src         = IMMSRC_W'(IMM_I);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                alu_ctrl       = ALUCTRL_W'(ALU_ADD);
                imm_src        = IMMSRC_W'(IMM_S);
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.funct3 = funct3;
                alu_ctrl    = ALUCTRL_W'(ALU_SUB);
                imm_src     = IMMSRC_W'(IMM_B);
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jal        = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = 1'b1;
                alu_ctrl        = ALUCTRL_W'(ALU_ADD);
                imm_src         = IMMSRC_W'(IMM_J);
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                alu_ctrl        = ALUCTRL_W'(ALU_ADD);
                imm_src         = IMMSRC_W'(IMM_I);
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = 1'b1;
                alu_ctrl       = ALUCTRL_W'(ALU_ADD);
                imm_src        = IMMSRC_W'(IMM_U);
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = 1'b1;
                alu_ctrl       = ALUCTRL_W'(ALU_ADD);
                imm_src        = IMMSRC_W'(IMM_U);
            end
            OP_SYSTEM: begin
                // Without CSR support SYSTEM is a harmless no-op, not illegal
                if (CSR_EN) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.result_src = RES_CSR;
                end
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: D decode, E/M/W control registers, branch
// resolution in E and the CSR drain FSM that serialises SYSTEM instructions.
//
// Issue rule: the instruction in D moves into E only when valid_d is high and
// nothing holds it back (stall_d, flush_e, a redirect from E, or a CSR drain);
// in every other cycle E is loaded with an all-zero bubble.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 5,
    parameter int IMMSRC_W  = 3,
    parameter bit CSR_EN    = 1'b1,
    parameter int DRAIN_CYC = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_d,
    input  logic                 flush_e,
    input  logic                 n_flag,
    input  logic                 z_flag,
    input  logic                 c_flag,
    input  logic                 v_flag,
    output logic [IMMSRC_W-1:0]  imm_src_d,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic [1:0]           alu_src_a_e,
    output logic                 alu_src_b_e,
    output logic                 mem_write_m,
    output logic [1:0]           result_src_w,
    output logic                 reg_write_m,
    output logic                 reg_write_w,
    output logic [1:0]           pc_src_e,
    output logic                 flush_d,
    output logic                 stall_req,
    output logic                 csr_busy,
    output logic                 illegal_e
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC);

    ctrl_t                dec_ctrl;
    logic [ALUCTRL_W-1:0] dec_alu;
    ctrl_t                e_q;
    logic [ALUCTRL_W-1:0] alu_e_q;
    ctrl_m_t              m_q;
    ctrl_w_t              w_q;
    csr_state_t           state, state_nxt;
    logic [2:0]           cnt, cnt_nxt;
    logic                 taken;
    logic                 load_bubble;
    logic                 csr_issue;
    logic                 unused_instr_bits;

    // Register indices and immediate bits are the datapath's business
    assign unused_instr_bits = ^{instr_d[31], instr_d[29:15], instr_d[11:7]};

    ctrl_decode #(
        .ALUCTRL_W (ALUCTRL_W),
        .IMMSRC_W  (IMMSRC_W),
        .CSR_EN    (CSR_EN)
    ) u_decode (
        .opcode   (instr_d[6:0]),
        .funct3   (instr_d[14:12]),
        .funct7_5 (instr_d[30]),
        .ctrl     (dec_ctrl),
        .alu_ctrl (dec_alu),
        .imm_src  (imm_src_d)
    );

    // Branch condition from the E-stage compare flags (C=1 means no borrow)
    always_comb begin
        taken = 1'b0;
        if (e_q.branch) begin
            case (e_q.funct3)
                F3_BEQ:  taken = z_flag;
                F3_BNE:  taken = !z_flag;
                F3_BLT:  taken = n_flag ^ v_flag;
                F3_BGE:  taken = !(n_flag ^ v_flag);
                F3_BLTU: taken = !c_flag;
                F3_BGEU: taken = c_flag;
                default: taken = 1'b0;
            endcase
        end
    end

    // Next-PC select; jal and jalr are mutually exclusive by decode
    always_comb begin
        pc_src_e = PCSRC_PC4;
        if (e_q.jalr) begin
            pc_src_e = PCSRC_ALU;
        end else if (e_q.jal || taken) begin
            pc_src_e = PCSRC_IMM;
        end
    end

    assign flush_d   = (pc_src_e != PCSRC_PC4);
    assign stall_req = (state == CSR_DRAIN);
    assign csr_busy  = (state == CSR_DRAIN);

    assign load_bubble = flush_e || flush_d || stall_d || stall_req || !valid_d;

    // A CSR starts draining only when it really lands in E (never while draining)
    assign csr_issue = CSR_EN && (instr_d[6:0] == OP_SYSTEM) && valid_d && !stall_d
                       && !flush_e && (pc_src_e == PCSRC_PC4);

    // Stage registers: E may take a bubble, M and W always advance
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            e_q     <= CTRL_BUBBLE;
            alu_e_q <= '0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            if (load_bubble) begin
                e_q     <= CTRL_BUBBLE;
                alu_e_q <= '0;
            end else begin
                e_q     <= dec_ctrl;
                alu_e_q <= dec_alu;
            end
            m_q.reg_write  <= e_q.reg_write;
            m_q.result_src <= e_q.result_src;
            m_q.mem_write  <= e_q.mem_write;
            w_q.reg_write  <= m_q.reg_write;
            w_q.result_src <= m_q.result_src;
        end
    end

    // CSR FSM state and drain counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= CSR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // CSR FSM next state: count DRAIN_CYC stall cycles, leave when counter reads 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CSR_IDLE: begin
                if (csr_issue) begin
                    state_nxt = CSR_DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end
            end
            CSR_DRAIN: begin
                if (cnt == 3'd1) begin
                    state_nxt = CSR_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = CSR_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign alu_ctrl_e   = alu_e_q;
    assign alu_src_a_e  = e_q.alu_src_a;
    assign alu_src_b_e  = e_q.alu_src_b;
    assign illegal_e    = e_q.illegal;
    assign mem_write_m  = m_q.mem_write;
    assign reg_write_m  = m_q.reg_write;
    assign reg_write_w  = w_q.reg_write;
    assign result_src_w = w_q.result_src;

endmodule
